// File: rtl/control_sequencer_if.sv
// Control-line bundle between the hardwired sequencer and the CPU datapath.
// Defining SEQ_SINGLE_STEP_EN adds the step input.
interface control_sequencer_if #(
  parameter int unsigned OPW = 5
);
  logic           run;
  logic           mem_ready;
  logic [31:0]    ir;
`ifdef SEQ_SINGLE_STEP_EN
  logic           step;
`endif
  logic           PCout, Zlowout, Zhighout, MDRout;
  logic           MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
  logic           IncPC, Read;
  logic           Gra, Grb, Grc, Rin, Rout;
  logic [OPW-1:0] alu_op;
  logic           halted;
  logic           illegal;

`ifdef SEQ_SINGLE_STEP_EN
  modport master (
    output run, mem_ready, ir, step,
    input  PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
           HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, halted, illegal
  );
  modport slave (
    input  run, mem_ready, ir, step,
    output PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
           HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, halted, illegal
  );
`else
  modport master (
    output run, mem_ready, ir,
    input  PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
           HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, halted, illegal
  );
  modport slave (
    input  run, mem_ready, ir,
    output PCout, Zlowout, Zhighout, MDRout, MARin, PCin, MDRin, IRin, Yin, Zin,
           HIin, LOin, IncPC, Read, Gra, Grb, Grc, Rin, Rout, alu_op, halted, illegal
  );
`endif
endinterface

// File: rtl/control_sequencer.sv
// Hardwired T0..T6 control sequencer for fetch and register-register ALU execute.
// Optional SEQ_SINGLE_STEP_EN gates every T-step transition on the step input.
module control_sequencer #(
  parameter int unsigned OPW  = 5,
  parameter int unsigned REGW = 4
) (
  input logic                clk,
  input logic                reset,
  control_sequencer_if.slave bus
);

  localparam int unsigned IRW  = 32;
  localparam int unsigned FLDW = 3 * REGW;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
  localparam logic [OPW-1:0] OP_SHRA = OPW'(5'b01000);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01001);
  localparam logic [OPW-1:0] OP_ROR  = OPW'(5'b01010);
  localparam logic [OPW-1:0] OP_ROL  = OPW'(5'b01011);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
  localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
  localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef enum logic [1:0] {
    CLS_BIN, CLS_MULDIV, CLS_UNARY, CLS_BAD
  } op_class_e;

  state_e          state_q, state_d;
  state_e          done_c;
  logic            t1_wait_q, t1_wait_d;
  logic            illegal_q, illegal_d;
  logic            adv_c;
  logic [OPW-1:0]  opcode_c;
  op_class_e       cls_c;
  logic            unused_fields_c;

  assign opcode_c        = bus.ir[IRW-1 -: OPW];
  assign unused_fields_c = ^{bus.ir[IRW-OPW-1 -: FLDW], bus.ir[IRW-OPW-FLDW-1:0]};
  assign done_c          = bus.run ? S_T0 : S_IDLE;

`ifdef SEQ_SINGLE_STEP_EN
  assign adv_c = bus.step;
`else
  assign adv_c = 1'b1;
`endif

  // Opcode class decode; anything not listed is an undecoded opcode.
  always_comb begin
    cls_c = CLS_BAD;
    case (opcode_c)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
      OP_SHL, OP_ROR, OP_ROL:                  cls_c = CLS_BIN;
      OP_MUL, OP_DIV:                          cls_c = CLS_MULDIV;
      OP_NEG, OP_NOT:                          cls_c = CLS_UNARY;
      default:                                 cls_c = CLS_BAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      t1_wait_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= t1_wait_d;
      illegal_q <= illegal_d;
    end
  end

  // Next state and Moore-decoded control word.
  always_comb begin
    state_d      = state_q;
    illegal_d    = illegal_q;
    t1_wait_d    = (state_q == S_T1);
    bus.PCout    = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zhighout = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCin     = 1'b0;
    bus.MDRin    = 1'b0;
    bus.IRin     = 1'b0;
    bus.Yin      = 1'b0;
    bus.Zin      = 1'b0;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Read     = 1'b0;
    bus.Gra      = 1'b0;
    bus.Grb      = 1'b0;
    bus.Grc      = 1'b0;
    bus.Rin      = 1'b0;
    bus.Rout     = 1'b0;
    bus.alu_op   = '0;
    bus.halted   = 1'b0;
    bus.illegal  = illegal_q;

    case (state_q)
      S_IDLE: if (bus.run) state_d = S_T0;
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        if (adv_c) state_d = S_T1;
      end
      S_T1: begin
        // PC reload happens once; the read strobe holds through memory wait.
        bus.Zlowout = 1'b1;
        bus.PCin    = !t1_wait_q;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        if (adv_c && bus.mem_ready) state_d = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        if (adv_c) state_d = S_T3;
      end
      S_T3: begin
        case (cls_c)
          CLS_BIN, CLS_MULDIV: begin
            bus.Grb  = 1'b1;
            bus.Rout = 1'b1;
            bus.Yin  = 1'b1;
            if (adv_c) state_d = S_T4;
          end
          CLS_UNARY: begin
            bus.Grb    = 1'b1;
            bus.Rout   = 1'b1;
            bus.Zin    = 1'b1;
            bus.alu_op = opcode_c;
            if (adv_c) state_d = S_T4;
          end
          default: begin
            if (adv_c) begin
              state_d   = S_HALT;
              illegal_d = 1'b1;
            end
          end
        endcase
      end
      S_T4: begin
        if (cls_c == CLS_UNARY) begin
          bus.Zlowout = 1'b1;
          bus.Gra     = 1'b1;
          bus.Rin     = 1'b1;
          if (adv_c) state_d = done_c;
        end else begin
          bus.Grc    = 1'b1;
          bus.Rout   = 1'b1;
          bus.Zin    = 1'b1;
          bus.alu_op = opcode_c;
          if (adv_c) state_d = S_T5;
        end
      end
      S_T5: begin
        if (cls_c == CLS_MULDIV) begin
          bus.Zlowout = 1'b1;
          bus.LOin    = 1'b1;
          if (adv_c) state_d = S_T6;
        end else begin
          bus.Zlowout = 1'b1;
          bus.Gra     = 1'b1;
          bus.Rin     = 1'b1;
          if (adv_c) state_d = done_c;
        end
      end
      S_T6: begin
        bus.Zhighout = 1'b1;
        bus.HIin     = 1'b1;
        if (adv_c) state_d = done_c;
      end
      S_HALT: bus.halted = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: expected control words come from a
// per-class step table built from the instruction-set rules.
module tb_control_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_sequencer_if sif ();

  control_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  localparam logic [23:0] W_PCOUT    = 24'h000001;
  localparam logic [23:0] W_ZLOWOUT  = 24'h000002;
  localparam logic [23:0] W_ZHIGHOUT = 24'h000004;
  localparam logic [23:0] W_MDROUT   = 24'h000008;
  localparam logic [23:0] W_MARIN    = 24'h000010;
  localparam logic [23:0] W_PCIN     = 24'h000020;
  localparam logic [23:0] W_MDRIN    = 24'h000040;
  localparam logic [23:0] W_IRIN     = 24'h000080;
  localparam logic [23:0] W_YIN      = 24'h000100;
  localparam logic [23:0] W_ZIN      = 24'h000200;
  localparam logic [23:0] W_HIIN     = 24'h000400;
  localparam logic [23:0] W_LOIN     = 24'h000800;
  localparam logic [23:0] W_INCPC    = 24'h001000;
  localparam logic [23:0] W_READ     = 24'h002000;
  localparam logic [23:0] W_GRA      = 24'h004000;
  localparam logic [23:0] W_GRB      = 24'h008000;
  localparam logic [23:0] W_GRC      = 24'h010000;
  localparam logic [23:0] W_RIN      = 24'h020000;
  localparam logic [23:0] W_ROUT     = 24'h040000;
  localparam logic [23:0] T0_W       = W_PCOUT | W_MARIN | W_INCPC | W_ZIN;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  logic [4:0]  legal_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                  5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

  // {halted, illegal, alu_op, Rout .. PCout}
  function automatic logic [25:0] observe();
    return {sif.halted, sif.illegal, sif.alu_op, sif.Rout, sif.Rin, sif.Grc, sif.Grb,
            sif.Gra, sif.Read, sif.IncPC, sif.LOin, sif.HIin, sif.Zin, sif.Yin, sif.IRin,
            sif.MDRin, sif.PCin, sif.MARin, sif.MDRout, sif.Zhighout, sif.Zlowout,
            sif.PCout};
  endfunction

  // 0 binary, 1 mul/div, 2 unary, 3 undecoded
  function automatic int op_class(input logic [4:0] op);
    if (op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11}) return 0;
    if (op inside {5'd15, 5'd16}) return 1;
    if (op inside {5'd17, 5'd18}) return 2;
    return 3;
  endfunction

  // Expected control word for every cycle from T0 entry to the last execute step.
  function automatic void model_instr(input logic [4:0] op, input int stall);
    logic [23:0] alu;
    alu = {op, 19'd0};
    exp_q.delete();
    exp_q.push_back(T0_W);
    exp_q.push_back(W_ZLOWOUT | W_PCIN | W_READ | W_MDRIN);
    for (int k = 0; k < stall; k++) exp_q.push_back(W_ZLOWOUT | W_READ | W_MDRIN);
    exp_q.push_back(W_MDROUT | W_IRIN);
    case (op_class(op))
      0: begin
        exp_q.push_back(W_GRB | W_ROUT | W_YIN);
        exp_q.push_back(W_GRC | W_ROUT | W_ZIN | alu);
        exp_q.push_back(W_ZLOWOUT | W_GRA | W_RIN);
      end
      1: begin
        exp_q.push_back(W_GRB | W_ROUT | W_YIN);
        exp_q.push_back(W_GRC | W_ROUT | W_ZIN | alu);
        exp_q.push_back(W_ZLOWOUT | W_LOIN);
        exp_q.push_back(W_ZHIGHOUT | W_HIIN);
      end
      2: begin
        exp_q.push_back(W_GRB | W_ROUT | W_ZIN | alu);
        exp_q.push_back(W_ZLOWOUT | W_GRA | W_RIN);
      end
      default: exp_q.push_back(24'd0);
    endcase
  endfunction

  function automatic logic [4:0] rand_legal();
    return legal_ops[$urandom_range(0, 12)];
  endfunction

  // Runs one instruction starting in T0, comparing the control word every cycle.
  // drop_at / rst_at: cycle index at which run is dropped / reset is asserted (-1 = never).
  task automatic test_instr(input string name, input logic [31:0] ir, input int stall,
                            input int drop_at, input int rst_at);
    logic [25:0] got;
    logic [25:0] exp;
    model_instr(ir[31:27], stall);
    sif.ir = ir;
    for (int i = 0; i < exp_q.size(); i++) begin
      got = observe();
      exp = {2'b00, exp_q[i]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, i, got, exp);
      end
      sif.mem_ready = (i >= 1 && i <= stall) ? 1'b0 : 1'b1;
      if (i == drop_at) sif.run = 1'b0;
      if (i == rst_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        got = observe();
        checks++;
        if (got !== 26'd0) begin
          errors++;
          $display("FAIL %s abort: got %h expected %h", name, got, 26'd0);
        end
        reset   = 1'b0;
        sif.run = 1'b1;
        @(posedge clk); #1;
        got = observe();
        checks++;
        if (got !== {2'b00, T0_W}) begin
          errors++;
          $display("FAIL %s restart: got %h expected %h", name, got, {2'b00, T0_W});
        end
        return;
      end
      @(posedge clk); #1;
    end
    if (op_class(ir[31:27]) != 3) begin
      got = observe();
      exp = sif.run ? {2'b00, T0_W} : 26'd0;
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s follow-on: got %h expected %h", name, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    logic [25:0] got;
    reset         = 1'b1;
    sif.run       = 1'b1;
    sif.mem_ready = 1'b1;
    sif.ir        = 32'd0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      got = observe();
      checks++;
      if (got !== 26'd0) begin
        errors++;
        $display("FAIL reset cycle %0d: got %h expected %h", i, got, 26'd0);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    got = observe();
    checks++;
    if (got !== {2'b00, T0_W}) begin
      errors++;
      $display("FAIL reset release: got %h expected %h", got, {2'b00, T0_W});
    end
  endtask

  task automatic test_and_directed();
    test_instr("and_r1_r2_r3", 32'h28918000, 0, -1, -1);
  endtask

  task automatic test_classes();
    logic [4:0] ops [4] = '{5'd15, 5'd16, 5'd17, 5'd18};
    for (int k = 0; k < 4; k++)
      test_instr("mul_div_unary", {ops[k], 27'($urandom)}, int'($urandom_range(0, 3)), -1, -1);
  endtask

  task automatic test_mem_stall();
    test_instr("mem_stall", {5'd3, 27'($urandom)}, 3, -1, -1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++)
      test_instr("back_to_back", {rand_legal(), 27'($urandom)}, int'($urandom_range(0, 3)), -1, -1);
  endtask

  task automatic test_run_drop();
    logic [25:0] got;
    int stall;
    stall = int'($urandom_range(0, 2));
    test_instr("run_drop", {rand_legal(), 27'($urandom)}, stall, 3 + stall, -1);
    @(posedge clk); #1;
    got = observe();
    checks++;
    if (got !== 26'd0) begin
      errors++;
      $display("FAIL run_drop idle hold: got %h expected %h", got, 26'd0);
    end
    sif.run = 1'b1;
    @(posedge clk); #1;
    got = observe();
    checks++;
    if (got !== {2'b00, T0_W}) begin
      errors++;
      $display("FAIL run_drop resume: got %h expected %h", got, {2'b00, T0_W});
    end
  endtask

  task automatic test_reset_mid();
    int stall;
    stall = int'($urandom_range(0, 2));
    test_instr("reset_mid_add", {5'd3, 27'($urandom)}, stall, -1, 4 + stall);
  endtask

  task automatic test_illegal(input logic [4:0] op);
    logic [25:0] got;
    test_instr("illegal_fetch", {op, 27'($urandom)}, 0, -1, -1);
    for (int i = 0; i < 10; i++) begin
      got = observe();
      checks++;
      if (got !== {2'b11, 24'd0}) begin
        errors++;
        $display("FAIL halt cycle %0d op %0d: got %h expected %h", i, op, got, {2'b11, 24'd0});
      end
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    got = observe();
    checks++;
    if (got !== 26'd0) begin
      errors++;
      $display("FAIL halt reset: got %h expected %h", got, 26'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    got = observe();
    checks++;
    if (got !== {2'b00, T0_W}) begin
      errors++;
      $display("FAIL halt restart: got %h expected %h", got, {2'b00, T0_W});
    end
  endtask

  initial begin
`ifdef SEQ_SINGLE_STEP_EN
    sif.step = 1'b1;
`endif
    test_reset();
    test_and_directed();
    test_classes();
    test_mem_stall();
    test_back_to_back();
    test_run_drop();
    test_reset_mid();
    test_illegal(5'b11111);
    test_illegal(($urandom_range(0, 1) == 0) ? 5'($urandom_range(12, 14))
                                             : 5'($urandom_range(19, 30)));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
